pipe_scroller: RTL

- Upstream pipe source for game_controller.
- Produces the scrolling pipe's left-edge X and the gap edges (pipe_x, pipe_y_top, pipe_y_bot) that game_controller consumes for collision checks.
- Advances once per frame_tick while the game runs and respawns the pipe at the right edge with an LFSR-chosen gap height.
- Generates the score pulse and score count when the pipe passes the bird.

---
 rtl/pipe_scroller.sv | 119 +++++++++++
 1 files changed

// File: rtl/pipe_scroller.sv
// Scrolling pipe source: moves the pipe left once per frame_tick, respawns it with an LFSR gap, and scores passes.
// Optional macro PIPE_SPEEDUP_EN: step grows with score (SCROLL_SPEED + score/8, capped at 2*SCROLL_SPEED).
//
// state  | meaning
// IDLE   | pipe parked at respawn position, waiting for run
// SCROLL | game in play, pipe advances on frame_tick
// HOLD   | game over freeze, outputs held until restart
module pipe_scroller #(
  parameter int SCREEN_WIDTH = 640,
  parameter int PIPE_WIDTH   = 50,
  parameter int PIPE_GAP     = 100,
  parameter int BIRD_X       = 500,
  parameter int SCROLL_SPEED = 2,
  parameter int GAP_Y_MIN    = 120,
  parameter int GAP_Y_MAX    = 360,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       run,
  input  logic       restart,
  output logic [9:0] pipe_x,
  output logic [9:0] pipe_y_top,
  output logic [9:0] pipe_y_bot,
  output logic [9:0] gap_y,
  output logic       score_pulse,
  output logic [7:0] score
);

  localparam int GAP_RANGE = GAP_Y_MAX - GAP_Y_MIN + 1;
  localparam int GAP_MID   = (GAP_Y_MIN + GAP_Y_MAX) / 2;
  localparam int HALF_GAP  = PIPE_GAP / 2;

  typedef enum logic [1:0] {IDLE, SCROLL, HOLD} state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic        lfsr_fb;
  logic [4:0]  step;
  logic [9:0]  x_next;
  logic [10:0] old_edge;
  logic [10:0] new_edge;
  logic        passed;
  logic        respawn;
  logic [9:0]  gap_raw;
  logic [9:0]  gap_new;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

`ifdef PIPE_SPEEDUP_EN
  logic [5:0] step_raw;
  assign step_raw = 6'(SCROLL_SPEED) + {1'b0, score[7:3]};
  assign step = (step_raw > 6'(2 * SCROLL_SPEED)) ? 5'(2 * SCROLL_SPEED) : step_raw[4:0];
`else
  assign step = 5'(SCROLL_SPEED);
`endif

  assign respawn  = pipe_x < {5'b0, step};
  assign x_next   = pipe_x - {5'b0, step};
  // Trailing edge crossing the bird, evaluated in 11 bits so pipe_x+PIPE_WIDTH cannot wrap.
  assign old_edge = {1'b0, pipe_x} + 11'(PIPE_WIDTH);
  assign new_edge = {1'b0, x_next} + 11'(PIPE_WIDTH);
  assign passed   = (old_edge >= 11'(BIRD_X)) && (new_edge < 11'(BIRD_X));

  // GAP_Y_MIN + 255 stays well inside 10 bits, so one conditional subtract folds it into range.
  assign gap_raw = 10'(GAP_Y_MIN) + {2'b0, lfsr[7:0]};
  assign gap_new = (gap_raw > 10'(GAP_Y_MAX)) ? gap_raw - 10'(GAP_RANGE) : gap_raw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      lfsr        <= LFSR_SEED;
      pipe_x      <= 10'(SCREEN_WIDTH);
      gap_y       <= 10'(GAP_MID);
      pipe_y_top  <= 10'(GAP_MID - HALF_GAP);
      pipe_y_bot  <= 10'(GAP_MID + HALF_GAP);
      score       <= 8'd0;
      score_pulse <= 1'b0;
    end else begin
      lfsr        <= {lfsr[14:0], lfsr_fb};
      score_pulse <= 1'b0;
      if (restart) begin
        state      <= IDLE;
        pipe_x     <= 10'(SCREEN_WIDTH);
        gap_y      <= 10'(GAP_MID);
        pipe_y_top <= 10'(GAP_MID - HALF_GAP);
        pipe_y_bot <= 10'(GAP_MID + HALF_GAP);
        score      <= 8'd0;
      end else begin
        case (state)
          IDLE: begin
            if (run) state <= SCROLL;
          end
          SCROLL: begin
            if (frame_tick) begin
              if (respawn) begin
                pipe_x     <= 10'(SCREEN_WIDTH);
                gap_y      <= gap_new;
                pipe_y_top <= gap_new - 10'(HALF_GAP);
                pipe_y_bot <= gap_new + 10'(HALF_GAP);
              end else begin
                pipe_x <= x_next;
                if (passed) begin
                  score_pulse <= 1'b1;
                  if (score != 8'hFF) score <= score + 8'd1;
                end
              end
            end
            if (!run) state <= HOLD;
          end
          HOLD: state <= HOLD;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
